poa_chain_validator: RTL and testbench

Parametrised Proof-of-Authority block validator for the OBChain datapath, next generation of the fixed three-validator checker. It keeps a writable registry of authorised signers and enforces round-robin signing turns. It checks hash-chain linkage and timestamp monotonicity, and commits the chain head only for accepted blocks. Upstream block sources feed it through a valid/ready request port; downstream logic consumes one verdict per block through a valid/ready response port.

---
 rtl/poa_pkg.sv | 19 +
 rtl/poa_registry.sv | 40 ++++
 rtl/poa_chain_validator.sv | 160 ++++++++++++++++
 tb/tb_poa_chain_validator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poa_pkg.sv
// Shared types for the PoA chain validator: verdict reason codes
// and default widths.
package poa_pkg;

  localparam int unsigned DEF_NUM_VALIDATORS = 3;
  localparam int unsigned DEF_ID_W           = 32;
  localparam int unsigned DEF_HASH_W         = 256;
  localparam int unsigned DEF_TS_W           = 32;
  localparam int unsigned DEF_HEIGHT_W       = 32;

  typedef enum logic [2:0] {
    RSN_OK          = 3'd0,
    RSN_UNAUTH      = 3'd1,
    RSN_OUT_OF_TURN = 3'd2,
    RSN_BAD_PREV    = 3'd3,
    RSN_STALE_TS    = 3'd4
  } poa_reason_e;

endpackage

// File: rtl/poa_registry.sv
// Authorised-signer registry: NUM_VALIDATORS slots of {id, en}.
// Ports: clk/reset, write port (we, widx, wid, wen), read (ridx -> rid, ren).
module poa_registry
  import poa_pkg::*;
#(
  parameter int unsigned NUM_VALIDATORS = DEF_NUM_VALIDATORS,
  parameter int unsigned ID_W           = DEF_ID_W,
  parameter int unsigned IDX_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [ID_W-1:0]  wid,
  input  logic             wen,
  input  logic [IDX_W-1:0] ridx,
  output logic [ID_W-1:0]  rid,
  output logic             ren
);

  logic [ID_W-1:0] ids [NUM_VALIDATORS];
  logic            ens [NUM_VALIDATORS];

  // Slot i comes out of reset as id i+1, enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_VALIDATORS); i++) begin
        ids[i] <= ID_W'(i + 1);
        ens[i] <= 1'b1;
      end
    end else if (we && (32'(widx) < NUM_VALIDATORS)) begin
      ids[widx] <= wid;
      ens[widx] <= wen;
    end
  end

  assign rid = ids[ridx];
  assign ren = ens[ridx];

endmodule

// File: rtl/poa_chain_validator.sv
// PoA block validator: registry scan, turn/linkage/timestamp checks,
// chain head commit. Ports: in_* request, cfg_* registry, out_* verdict.
module poa_chain_validator
  import poa_pkg::*;
#(
  parameter int unsigned         NUM_VALIDATORS = DEF_NUM_VALIDATORS,
  parameter int unsigned         ID_W           = DEF_ID_W,
  parameter int unsigned         HASH_W         = DEF_HASH_W,
  parameter int unsigned         TS_W           = DEF_TS_W,
  parameter int unsigned         HEIGHT_W       = DEF_HEIGHT_W,
  parameter bit                  IN_TURN        = 1'b1,
  parameter logic [HASH_W-1:0]   GENESIS_HASH   = 256'habc123456
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ID_W-1:0]     in_validator_id,
  input  logic [HASH_W-1:0]   in_prev_hash,
  input  logic [HASH_W-1:0]   in_hash,
  input  logic [TS_W-1:0]     in_timestamp,
  input  logic                cfg_we,
  output logic                cfg_ready,
  input  logic [$clog2(NUM_VALIDATORS > 1 ? NUM_VALIDATORS : 2)-1:0] cfg_idx,
  input  logic [ID_W-1:0]     cfg_id,
  input  logic                cfg_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_accept,
  output logic [2:0]          out_reason,
  output logic [HEIGHT_W-1:0] out_height,
  output logic [HASH_W-1:0]   head_hash
);

  localparam int unsigned IDX_W =
    $clog2(NUM_VALIDATORS > 1 ? NUM_VALIDATORS : 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VALIDATORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_e;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [HASH_W-1:0] prev;
    logic [HASH_W-1:0] hash;
    logic [TS_W-1:0]   ts;
  } blk_t;

  state_e              state, state_nx;
  blk_t                blk;
  logic [IDX_W-1:0]    scan_idx, match_idx_q, match_idx, turn_ptr;
  logic                match_q, hit, found, scan_last;
  logic [TS_W-1:0]     last_ts;
  logic [HEIGHT_W-1:0] height;
  logic [ID_W-1:0]     reg_rid;
  logic                reg_ren;
  poa_reason_e         verdict, reason_q;

  assign in_ready   = (state == S_IDLE);
  assign cfg_ready  = (state == S_IDLE);
  assign out_valid  = (state == S_RESP);
  assign out_reason = reason_q;
  assign out_height = height;

  poa_registry #(
    .NUM_VALIDATORS(NUM_VALIDATORS),
    .ID_W          (ID_W),
    .IDX_W         (IDX_W)
  ) u_registry (
    .clk  (clk),
    .reset(reset),
    .we   (cfg_we && (state == S_IDLE)),
    .widx (cfg_idx),
    .wid  (cfg_id),
    .wen  (cfg_en),
    .ridx (scan_idx),
    .rid  (reg_rid),
    .ren  (reg_ren)
  );

  // Include the slot read this cycle so the last slot can still match
  // on the same edge that produces the verdict.
  assign hit       = reg_ren && (reg_rid == blk.id);
  assign found     = match_q || hit;
  assign match_idx = match_q ? match_idx_q : scan_idx;
  assign scan_last = (scan_idx == LAST);

  always_comb begin
    verdict = RSN_OK;
    if (!found)
      verdict = RSN_UNAUTH;
    else if (IN_TURN && (match_idx != turn_ptr))
      verdict = RSN_OUT_OF_TURN;
    else if (blk.prev != head_hash)
      verdict = RSN_BAD_PREV;
    else if (blk.ts <= last_ts)
      verdict = RSN_STALE_TS;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nx = S_SCAN;
      S_SCAN:  if (scan_last) state_nx = S_RESP;
      S_RESP:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk         <= '0;
      scan_idx    <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      head_hash   <= GENESIS_HASH;
      last_ts     <= '0;
      height      <= '0;
      turn_ptr    <= '0;
      out_accept  <= 1'b0;
      reason_q    <= RSN_OK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            blk      <= '{in_validator_id, in_prev_hash,
                          in_hash, in_timestamp};
            scan_idx <= '0;
            match_q  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!match_q && hit) begin
            match_q     <= 1'b1;
            match_idx_q <= scan_idx;
          end
          if (scan_last) begin
            out_accept <= (verdict == RSN_OK);
            reason_q   <= verdict;
            if (verdict == RSN_OK) begin
              head_hash <= blk.hash;
              last_ts   <= blk.ts;
              height    <= height + HEIGHT_W'(1);
              turn_ptr  <= (turn_ptr == LAST) ? '0
                           : turn_ptr + IDX_W'(1);
            end
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poa_chain_validator.sv
// Scoreboard bench for poa_chain_validator: directed cases then
// randomized blocks/cfg writes against a behavioural chain model.
module tb_poa_chain_validator;
  import poa_pkg::*;

  localparam int N = 3;
  localparam logic [255:0] GEN = 256'habc123456;

  logic         clk, reset;
  logic         in_valid, in_ready;
  logic [31:0]  in_validator_id;
  logic [255:0] in_prev_hash, in_hash;
  logic [31:0]  in_timestamp;
  logic         cfg_we, cfg_ready;
  logic [1:0]   cfg_idx;
  logic [31:0]  cfg_id;
  logic         cfg_en;
  logic         out_valid, out_ready, out_accept;
  logic [2:0]   out_reason;
  logic [31:0]  out_height;
  logic [255:0] head_hash;

  poa_chain_validator #(
    .NUM_VALIDATORS(N), .ID_W(32), .HASH_W(256), .TS_W(32),
    .HEIGHT_W(32), .IN_TURN(1'b1), .GENESIS_HASH(GEN)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_validator_id(in_validator_id), .in_prev_hash(in_prev_hash),
    .in_hash(in_hash), .in_timestamp(in_timestamp),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_id(cfg_id), .cfg_en(cfg_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_accept(out_accept), .out_reason(out_reason),
    .out_height(out_height), .head_hash(head_hash)
  );

  typedef struct {
    logic         acc;
    logic [2:0]   rsn;
    logic [31:0]  h;
    logic [255:0] head;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit rand_bp = 0;

  logic [31:0]  m_id [N];
  bit           m_en [N];
  logic [255:0] m_head;
  logic [31:0]  m_last, m_height;
  int           m_turn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_id[i] = 32'(i + 1);
      m_en[i] = 1'b1;
    end
    m_head = GEN; m_last = 0; m_height = 0; m_turn = 0;
  endtask

  // Chain rules: lowest enabled matching slot, then turn, link, time.
  task automatic judge(input logic [31:0] id, input logic [255:0] prev,
                       input logic [255:0] hash, input logic [31:0] ts);
    exp_t e;
    int mi = -1;
    logic [2:0] r;
    for (int i = N - 1; i >= 0; i--)
      if (m_en[i] && m_id[i] == id) mi = i;
    if (mi < 0)               r = 3'd1;
    else if (mi != m_turn)    r = 3'd2;
    else if (prev != m_head)  r = 3'd3;
    else if (ts <= m_last)    r = 3'd4;
    else                      r = 3'd0;
    if (r == 3'd0) begin
      m_head = hash; m_last = ts; m_height = m_height + 1;
      m_turn = (m_turn + 1) % N;
    end
    e.acc = (r == 3'd0); e.rsn = r; e.h = m_height; e.head = m_head;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout got=0 want=1");
    end
  endtask

  task automatic send(input logic [31:0] id, input logic [255:0] prev,
                      input logic [255:0] hash, input logic [31:0] ts,
                      input bit do_cfg = 0, input logic [1:0] cidx = 0,
                      input logic [31:0] cid = 0, input bit cen = 0,
                      input bit push = 1);
    in_valid = 1; in_validator_id = id; in_prev_hash = prev;
    in_hash = hash; in_timestamp = ts;
    cfg_we = do_cfg; cfg_idx = cidx; cfg_id = cid; cfg_en = cen;
    wait_ready();
    if (do_cfg && int'(cidx) < N) begin
      m_id[cidx] = cid; m_en[cidx] = cen;
    end
    if (push) judge(id, prev, hash, ts);
    @(posedge clk); #1;
    in_valid = 0; cfg_we = 0;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] id,
                     input bit en);
    cfg_we = 1; cfg_idx = idx; cfg_id = id; cfg_en = en;
    wait_ready();
    if (int'(idx) < N) begin
      m_id[idx] = id; m_en[idx] = en;
    end
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d want=0", sb.size());
    end
  endtask

  // Monitor: a verdict with out_ready high completes at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_verdict got=%0d want=none", out_reason);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("accept", out_accept, e.acc);
        check("reason", out_reason, e.rsn);
        check("height", out_height, e.h);
        check("head", head_hash, e.head);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    logic [255:0] h1, h2, h3;
    logic         s_acc;
    logic [2:0]   s_rsn;
    logic [31:0]  s_h;
    h1 = 256'h1111; h2 = 256'h2222; h3 = 256'h3333;
    reset = 1; in_valid = 0; cfg_we = 0; out_ready = 1;
    in_validator_id = 0; in_prev_hash = 0; in_hash = 0;
    in_timestamp = 0; cfg_idx = 0; cfg_id = 0; cfg_en = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    model_reset();

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_head", head_hash, GEN);
    check("rst_height", out_height, 0);
    check("rst_accept", out_accept, 0);
    check("rst_reason", out_reason, 0);

    send(1, GEN, h1, 5);
    check("scan_in_ready", in_ready, 0);
    check("lat_c1", out_valid, 0);
    @(posedge clk); #1 check("lat_c2", out_valid, 0);
    @(posedge clk); #1 check("lat_c3", out_valid, 0);
    @(posedge clk); #1 check("lat_c4", out_valid, 1);
    drain();
    check("head_h1", head_hash, h1);

    send(3, h1, h2, 6);
    send(7, h1, h2, 6);
    cfg(0, 1, 0);
    send(1, h1, h2, 6);
    send(2, 256'hdead, h2, 6);
    send(2, h1, h2, 5);
    drain();
    check("head_kept", head_hash, m_head);
    check("height_kept", out_height, m_height);

    out_ready = 0;
    send(2, h1, h2, 10);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
    end
    check("bp_valid", out_valid, 1);
    s_acc = out_accept; s_rsn = out_reason; s_h = out_height;
    for (int i = 0; i < 10; i++) begin
      cfg_we = 1; cfg_idx = 2; cfg_id = 3; cfg_en = 0;
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_fields", {out_accept, out_reason, out_height},
            {s_acc, s_rsn, s_h});
      check("bp_in_ready", in_ready, 0);
      check("bp_cfg_ready", cfg_ready, 0);
    end
    cfg_we = 0;
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_idle", in_ready, 1);
    send(3, h2, h3, 11);
    drain();

    cfg(0, 1, 1);
    send(1, h3, 256'h4444, 12, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_head", head_hash, GEN);
    check("mid_rst_height", out_height, 0);
    repeat (6) @(posedge clk);
    #1;
    send(1, GEN, h1, 1);
    send(2, h1, h2, 2);
    send(3, h2, h3, 3);
    drain();
    check("restore_height", out_height, 3);

    rand_bp = 1;
    for (int k = 0; k < 150; k++) begin
      logic [31:0]  id, ts, cid;
      logic [255:0] prev, hash;
      bit           dc;
      logic [1:0]   ci;
      id = ($urandom_range(0, 7) < 5) ? m_id[m_turn]
           : 32'($urandom_range(1, 6));
      prev = ($urandom_range(0, 4) != 0) ? m_head
             : {224'h0, $urandom};
      hash = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
      ts = m_last + 32'($urandom_range(0, 3));
      ci = 2'($urandom_range(0, 3));
      cid = 32'($urandom_range(1, 5));
      dc = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0)
        cfg(ci, cid, ($urandom_range(0, 3) != 0));
      send(id, prev, hash, ts, dc, ci, cid,
           ($urandom_range(0, 3) != 0));
    end
    rand_bp = 0;
    @(posedge clk); #2;
    out_ready = 1;
    drain();
    check("final_head", head_hash, m_head);
    check("final_height", out_height, m_height);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
